seq_detector: RTL and testbench

- Serial bit-pattern detector: samples the 1-bit input x on each rising clk edge and flags when the most recent bits equal a fixed pattern (default 1101, first bit oldest).
- Mealy-style: z asserts in the same cycle the final pattern bit is present on x.
- Small gate-level benchmark block used for switching-activity/power estimation runs; no handshakes and no downstream back-pressure.

---
 rtl/seq_detector_pkg.sv | 7 +
 rtl/seq_detector.sv | 49 ++++
 tb/tb_seq_detector.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seq_detector_pkg.sv
// Shared defaults for the serial pattern detector, used by the RTL, the bench and the power scripts.
package seq_detector_pkg;

    localparam int                     DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_detector.sv
// Mealy serial bit-pattern detector: z flags when the last PAT_LEN-1 sampled bits plus the
// current x equal PATTERN (oldest bit first), with optional overlapping detection.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    localparam int               CNT_W   = $clog2(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic [PAT_LEN-1:0] window;
    logic               match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

    // The counter gates the match so the zero-filled history after reset never fakes a hit.
    always_comb begin
        window = {hist_q, x};
        match  = (cnt_q == CNT_MAX) && (window == PATTERN);
        hist_d = window[PAT_LEN-2:0];
        cnt_d  = cnt_q;
        if (!OVERLAP && match) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign z = rst & match;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: overlapping and non-overlapping 1101 detectors plus a
// 0001 detector that exposes any false match from the zero-filled history.
module tb_seq_detector;
    import seq_detector_pkg::*;

    logic clk;
    logic rst;
    logic x;
    logic z_ov;
    logic z_nov;
    logic z_zero;

    int checks;
    int failures;

    seq_detector #(
        .PAT_LEN (DEF_PAT_LEN),
        .PATTERN (DEF_PATTERN),
        .OVERLAP (1'b1)
    ) dut_ov (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z_ov)
    );

    seq_detector #(
        .PAT_LEN (DEF_PAT_LEN),
        .PATTERN (DEF_PATTERN),
        .OVERLAP (1'b0)
    ) dut_nov (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z_nov)
    );

    seq_detector #(
        .PAT_LEN (4),
        .PATTERN (4'b0001),
        .OVERLAP (1'b1)
    ) dut_zero (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    // Drives one bit in the low clock phase, checks the Mealy outputs, then lets the edge consume it.
    task automatic applyStimulus(input string tag, input logic bit_val,
                                 input logic exp_ov, input logic exp_nov);
        x = bit_val;
        #1;
        checkOutput({tag, "_ov"}, z_ov, exp_ov);
        checkOutput({tag, "_nov"}, z_nov, exp_nov);
        @(negedge clk);
    endtask

    task automatic applyZeroStim(input string tag, input logic bit_val, input logic exp_zero);
        x = bit_val;
        #1;
        checkOutput({tag, "_zero"}, z_zero, exp_zero);
        @(negedge clk);
    endtask

    // Bits are sent MSB first, from position n-1 down to 0.
    task automatic runSeq(input string name, input int n, input logic [15:0] bits,
                          input logic [15:0] exp_ov, input logic [15:0] exp_nov);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus($sformatf("%s_b%0d", name, n - i), bits[i], exp_ov[i], exp_nov[i]);
        end
    endtask

    task automatic doReset(input string tag);
        rst = 1'b0;
        #1;
        checkOutput({tag, "_rst_ov"}, z_ov, 1'b0);
        checkOutput({tag, "_rst_nov"}, z_nov, 1'b0);
        checkOutput({tag, "_rst_zero"}, z_zero, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        x        = 1'b0;

        $display("[TB] reset with x toggling");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = ~x;
            #1;
            checkOutput($sformatf("inrst%0d_ov", i), z_ov, 1'b0);
            checkOutput($sformatf("inrst%0d_nov", i), z_nov, 1'b0);
            checkOutput($sformatf("inrst%0d_zero", i), z_zero, 1'b0);
        end
        rst = 1'b1;

        $display("[TB] basic hit");
        runSeq("basic", 5, 16'b01101, 16'b00001, 16'b00001);

        $display("[TB] overlap vs non-overlap");
        doReset("ovl");
        runSeq("ovl", 7, 16'b1101101, 16'b0001001, 16'b0001000);

        $display("[TB] near misses");
        doReset("near");
        runSeq("near", 16, 16'b1111_1001_1100_1101,
               16'b0000_0000_0000_0001, 16'b0000_0000_0000_0001);

        $display("[TB] reset mid-pattern");
        doReset("mid");
        runSeq("mid_pre", 3, 16'b110, 16'b000, 16'b000);
        doReset("mid_pulse");
        runSeq("mid_post", 4, 16'b1101, 16'b0001, 16'b0001);

        $display("[TB] reset while match present");
        doReset("drop");
        runSeq("drop_pre", 3, 16'b110, 16'b000, 16'b000);
        x = 1'b1;
        #1;
        checkOutput("drop_hit_ov", z_ov, 1'b1);
        checkOutput("drop_hit_nov", z_nov, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("drop_fall_ov", z_ov, 1'b0);
        checkOutput("drop_fall_nov", z_nov, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        runSeq("drop_post", 4, 16'b1101, 16'b0001, 16'b0001);

        $display("[TB] zero-filled history with pattern 0001");
        doReset("zero");
        applyZeroStim("zero_b1", 1'b1, 1'b0);
        applyZeroStim("zero_b2", 1'b0, 1'b0);
        applyZeroStim("zero_b3", 1'b0, 1'b0);
        applyZeroStim("zero_b4", 1'b0, 1'b0);
        applyZeroStim("zero_b5", 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
